// File: rtl/ultrasonic_ranger_pkg.sv
// Shared types and sizing helpers for the ultrasonic ranger.
package ranger_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_ECHO,
        S_MEASURE,
        S_DONE,
        S_HOLDOFF
    } state_t;

    // Bits needed to hold 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ultrasonic_ranger_echo_sync.sv
// Two-flop synchronizer for the echo pin plus rise/fall edge detection.
module echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic echo,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_s1;
    logic r_s2;
    logic r_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_d  <= 1'b0;
        end else begin
            r_s1 <= echo;
            r_s2 <= r_s1;
            r_d  <= r_s2;
        end
    end

    assign level = r_s2;
    assign rise  = r_s2 & ~r_d;
    assign fall  = ~r_s2 & r_d;

endmodule

// File: rtl/ultrasonic_ranger.sv
// Trigger/echo timing FSM that converts echo pulse width into centimetres
// using a cycles-per-cm prescaler; timeouts report the maximum distance.
module ultrasonic_ranger
    import ranger_pkg::*;
#(
    parameter int PV_WIDTH       = 9,
    parameter int TRIG_CYCLES    = 1000,
    parameter int CYCLES_PER_CM  = 5800,
    parameter int TIMEOUT_CYCLES = 3_000_000,
    parameter int PERIOD_CYCLES  = 6_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                echo,
    output logic                trig,
    output logic                busy,
    output logic [PV_WIDTH-1:0] distance,
    output logic                distance_valid,
    output logic                timeout
);

    localparam int PW = cnt_w(PERIOD_CYCLES);
    localparam int TW = cnt_w(TIMEOUT_CYCLES);
    localparam int CW = cnt_w(CYCLES_PER_CM);

    localparam logic [PW-1:0]       L_TRIG_LAST = PW'(TRIG_CYCLES - 1);
    localparam logic [PW-1:0]       L_PER_LAST  = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0]       L_TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]       L_CPC_LAST  = CW'(CYCLES_PER_CM - 1);
    localparam logic [PV_WIDTH-1:0] L_MAX_DIST  = '1;

    state_t              r_state;
    state_t              w_next;
    logic [PW-1:0]       r_pcnt;
    logic [TW-1:0]       r_tocnt;
    logic [CW-1:0]       r_pre;
    logic [PV_WIDTH-1:0] r_cm;
    logic                r_to_hit;
    logic                r_trig;
    logic [PV_WIDTH-1:0] r_dist;
    logic                r_valid;
    logic                r_timeout;

    logic w_level;
    logic w_rise;
    logic w_fall;
    logic w_to_fire;
    logic w_enter_trig;
    logic w_enter_done;
    logic w_count_en;

    echo_sync u_echo_sync (
        .clk   (clk),
        .reset (reset),
        .echo  (echo),
        .level (w_level),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_to_fire = 1'b0;
        case (r_state)
            S_IDLE:      if (en) w_next = S_TRIG;
            S_TRIG:      if (r_pcnt == L_TRIG_LAST) w_next = S_WAIT_ECHO;
            S_WAIT_ECHO: begin
                // Timeout wins over a coincident rise so the counter can never run past its limit.
                if (r_tocnt == L_TO_LAST) begin
                    w_next    = S_DONE;
                    w_to_fire = 1'b1;
                end else if (w_rise) begin
                    w_next = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (w_fall) begin
                    w_next = S_DONE;
                end else if (r_tocnt == L_TO_LAST) begin
                    w_next    = S_DONE;
                    w_to_fire = 1'b1;
                end
            end
            S_DONE:      w_next = S_HOLDOFF;
            S_HOLDOFF:   if (r_pcnt == L_PER_LAST) w_next = en ? S_TRIG : S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    assign w_enter_trig = (w_next == S_TRIG) && (r_state != S_TRIG);
    assign w_enter_done = (w_next == S_DONE) && (r_state != S_DONE);
    // The rise cycle already has echo_s high, so it is counted as the first high cycle.
    assign w_count_en   = ((r_state == S_MEASURE) && w_level) ||
                          ((r_state == S_WAIT_ECHO) && w_rise);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcnt   <= '0;
            r_tocnt  <= '0;
            r_pre    <= '0;
            r_cm     <= '0;
            r_to_hit <= 1'b0;
        end else begin
            if (w_enter_trig || (w_next == S_IDLE)) r_pcnt <= '0;
            else                                    r_pcnt <= r_pcnt + 1'b1;

            if (r_state == S_TRIG)
                r_tocnt <= '0;
            else if ((r_state == S_WAIT_ECHO) || (r_state == S_MEASURE))
                r_tocnt <= r_tocnt + 1'b1;

            if (w_enter_trig) begin
                r_pre <= '0;
                r_cm  <= '0;
            end else if (w_count_en) begin
                if (r_pre == L_CPC_LAST) begin
                    r_pre <= '0;
                    if (r_cm != L_MAX_DIST) r_cm <= r_cm + 1'b1;
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end

            if (w_enter_done) r_to_hit <= w_to_fire;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trig    <= 1'b0;
            r_dist    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_trig  <= (w_next == S_TRIG);
            r_valid <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_dist    <= r_to_hit ? L_MAX_DIST : r_cm;
                r_timeout <= r_to_hit;
            end
        end
    end

    assign trig           = r_trig;
    assign busy           = (r_state != S_IDLE);
    assign distance       = r_dist;
    assign distance_valid = r_valid;
    assign timeout        = r_timeout;

endmodule

// File: doc/ultrasonic_ranger.md
# ultrasonic_ranger

Front-end distance sensor stage of the wall follower: drives the ultrasonic module's trigger pin, times the returned echo pulse, and produces an unsigned distance in centimetres. Its `distance` output feeds the PID controller's `feedback` input, and its one-cycle `distance_valid` strobe drives the controller's `en`. Division is done with a cycles-per-cm prescaler, so the block contains no divider and no multiplier.

## Interface
Parameters:
- `PV_WIDTH`, default 9: distance width; must equal the PID `PV_WIDTH`. Maximum reported distance is 2^PV_WIDTH-1.
- `TRIG_CYCLES`, default 1000: trigger pulse width in clocks (10 µs at 100 MHz).
- `CYCLES_PER_CM`, default 5800: echo-high clocks per centimetre (58 µs/cm at 100 MHz).
- `TIMEOUT_CYCLES`, default 3_000_000: maximum clocks from trigger fall to echo fall.
- `PERIOD_CYCLES`, default 6_000_000: clocks between successive trigger rising edges. Must exceed TRIG_CYCLES+TIMEOUT_CYCLES+4.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high.
- `en`, in, 1: continuous ranging enable.
- `echo`, in, 1: asynchronous echo pin from the sensor.
- `trig`, out, 1: trigger pin; registered.
- `busy`, out, 1: high in any state other than IDLE.
- `distance`, out, PV_WIDTH: last measured distance; holds its value between measurements.
- `distance_valid`, out, 1: one-cycle strobe when `distance` updates.
- `timeout`, out, 1: qualifies the last measurement; updates together with `distance`.

## Operation
- **Synchronisation:** `echo` passes through a 2-flop synchronizer, giving `echo_s`. A third flop provides edges: rise = `echo_s & ~echo_d`, fall = `~echo_s & echo_d`. Raw `echo` is never used in logic.
- **State machine:**
  - IDLE → TRIG when `en` = 1.
  - TRIG: `trig` = 1 for exactly TRIG_CYCLES clocks, then → WAIT_ECHO.
  - WAIT_ECHO → MEASURE on a rise.
  - MEASURE: while `echo_s` = 1, a prescaler counts 0..CYCLES_PER_CM-1. On each wrap the cm counter increments, saturating at 2^PV_WIDTH-1. On a fall → DONE.
  - DONE: for one cycle, `distance` ← cm counter, `timeout` ← 0, `distance_valid` = 1; then → HOLDOFF.
  - HOLDOFF: wait until the period counter reaches PERIOD_CYCLES-1, then → TRIG if `en`, else → IDLE. Echo edges are ignored here.
- **Timeout:** a counter starts at trigger fall and runs through WAIT_ECHO and MEASURE. When it reaches TIMEOUT_CYCLES, take the DONE path with `distance` = 2^PV_WIDTH-1 and `timeout` = 1. Downstream therefore sees "no wall" as maximum distance.
- **Distance arithmetic:** result = floor(synchronised high cycles / CYCLES_PER_CM), saturated. The prescaler and cm counter clear on entry to TRIG.
- **Echo already high at trigger:** no rise is ever seen, so the measurement ends in timeout.
- **`en` deasserted mid-measurement:** the current measurement completes and reports normally, then HOLDOFF → IDLE.
- **Reset:** asynchronous at any point. `trig`, `busy`, `distance_valid` and `timeout` = 0; `distance` = 0; state = IDLE; all counters and synchronizer flops = 0.

## Timing
- A `distance_valid` strobe is exactly one clock wide, and `distance`/`timeout` are stable from that cycle onward.
- A pin-level echo fall, meeting setup, asserts `distance_valid` on the 4th rising edge: 2 synchronizer edges, the edge-detect/DONE-entry edge, then the registered output.
- Trigger rising edges are exactly PERIOD_CYCLES apart while `en` is held high.
- From IDLE, `en` sampled high puts `trig` high one clock later.
- Timeout fires exactly TIMEOUT_CYCLES clocks after `trig` falls; `distance_valid` follows one clock later.

## Structure
- **`ranger_pkg`:** state enum typedef (IDLE, TRIG, WAIT_ECHO, MEASURE, DONE, HOLDOFF) and a helper for counter widths (`$clog2` of each cycle parameter).
- **Sub-module `echo_sync`:** 2-flop synchronizer plus edge detect, with outputs `level`, `rise` and `fall`. It uses the same asynchronous reset.
- The top level contains the FSM and the four counters: trig/period, timeout, prescaler and cm.

## Test plan
Bench parameters: PV_WIDTH=6, TRIG_CYCLES=10, CYCLES_PER_CM=4, TIMEOUT_CYCLES=400, PERIOD_CYCLES=600.
1. Reset asserted with `echo` toggling → all outputs 0 and `trig` stays low; release reset with `en`=0 → `busy` remains 0.
2. `en`=1; `echo` rises 5 cycles after `trig` falls and stays high 40 cycles → `distance`=10, `timeout`=0, one-cycle valid 4 edges after the echo fall. Repeat with 39 cycles high → `distance`=9.
3. `echo` high for 300 cycles → `distance`=63 (saturated), `timeout`=0.
4. `echo` never rises; then a second run with `echo` stuck high before the trigger → both runs give valid exactly 401 cycles after `trig` falls, `distance`=63, `timeout`=1.
5. `en` held high → `trig` rising edges exactly 600 cycles apart. Drop `en` during MEASURE → that result is still reported, no further `trig`, and `busy` falls at the period end.
6. Assert `reset` mid-MEASURE → `trig`/`busy` drop immediately and `distance`=0. Release with `en`=1 → a fresh trigger starts and a 20-cycle echo reports 5.
